// File: rtl/scr1_dmem_arb_pkg.sv
// Shared types for the DMEM arbiter: memory interface enums, requester ids, request payload.
package scr1_dmem_arb_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_DMEM_ARB_LSU = 1'b0,
    SCR1_DMEM_ARB_EXT = 1'b1
  } type_scr1_dmem_arb_id_e;

  // Request payload forwarded downstream from the granted requester
  typedef struct packed {
    type_scr1_mem_cmd_e          cmd;
    type_scr1_mem_width_e        width;
    logic [SCR1_DMEM_AWIDTH-1:0] addr;
    logic [SCR1_DMEM_DWIDTH-1:0] wdata;
  } type_scr1_dmem_arb_req_s;

  // A response terminates the transaction when it is anything but NOTRDY
  function automatic logic resp_done(input type_scr1_mem_resp_e resp);
    return (resp == SCR1_MEM_RESP_RDY_OK) || (resp == SCR1_MEM_RESP_RDY_ER);
  endfunction

endpackage

// File: rtl/scr1_dmem_arb_if.sv
// Single-outstanding memory request/response channel.
interface scr1_dmem_arb_if;
  import scr1_dmem_arb_pkg::*;

  logic                        req;
  type_scr1_mem_cmd_e          cmd;
  type_scr1_mem_width_e        width;
  logic [SCR1_DMEM_AWIDTH-1:0] addr;
  logic [SCR1_DMEM_DWIDTH-1:0] wdata;
  logic                        req_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] rdata;
  type_scr1_mem_resp_e         resp;

  // Issuer of requests
  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, rdata, resp
  );

  // Acceptor of requests
  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, rdata, resp
  );

endinterface

// File: rtl/scr1_arb_rr2.sv
// Two-way grant selector with lock on un-acked grants and round-robin or fixed priority.
module scr1_arb_rr2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       ack,
  output logic       grant
);

  logic rr_last;
  logic lock_vld;
  logic lock_id;
  logic lock_hit;

  assign lock_hit = lock_vld & req[lock_id];

  // Grant selection: a live lock wins, otherwise single requester or priority/round-robin
  always_comb begin
    grant = 1'b0;
    if (lock_hit) begin
      grant = lock_id;
    end else begin
      case (req)
        2'b10:   grant = 1'b1;
        2'b11:   grant = FIXED_PRIO ? 1'b0 : ~rr_last;
        default: grant = 1'b0;
      endcase
    end
  end

  // Round-robin history and lock tracking; a dropped locked request simply re-arbitrates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last  <= 1'b1;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
    end else if (en) begin
      if (|req) begin
        if (ack) begin
          rr_last  <= grant;
          lock_vld <= 1'b0;
        end else begin
          lock_vld <= 1'b1;
          lock_id  <= grant;
        end
      end else begin
        lock_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/scr1_dmem_arb.sv
// Shares the core DMEM port between the LSU (r0) and a secondary data master (r1).
module scr1_dmem_arb
  import scr1_dmem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  scr1_dmem_arb_if.slave  r0,
  scr1_dmem_arb_if.slave  r1,
  scr1_dmem_arb_if.master dmem,
  output logic            arb_busy,
  output logic            arb_owner
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fsm_e;

  fsm_e                    state;
  fsm_e                    state_next;
  type_scr1_dmem_arb_id_e  owner;
  type_scr1_dmem_arb_req_s r0_pl;
  type_scr1_dmem_arb_req_s r1_pl;
  type_scr1_dmem_arb_req_s sel_pl;
  logic                    idle;
  logic                    req_any;
  logic                    grant;
  logic                    issue;

  assign idle    = (state == ST_IDLE);
  assign req_any = r0.req | r1.req;
  assign issue   = idle & req_any & dmem.req_ack;

  assign r0_pl  = '{cmd: r0.cmd, width: r0.width, addr: r0.addr, wdata: r0.wdata};
  assign r1_pl  = '{cmd: r1.cmd, width: r1.width, addr: r1.addr, wdata: r1.wdata};
  assign sel_pl = grant ? r1_pl : r0_pl;

  scr1_arb_rr2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (idle),
    .req   ({r1.req, r0.req}),
    .ack   (dmem.req_ack),
    .grant (grant)
  );

  // State and owner registers; reset abandons any outstanding transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= SCR1_DMEM_ARB_LSU;
    end else begin
      state <= state_next;
      if (issue) begin
        owner <= type_scr1_dmem_arb_id_e'(grant);
      end
    end
  end

  // Next state: accept moves to BUSY, any final response returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (issue) state_next = ST_BUSY;
      ST_BUSY: if (resp_done(dmem.resp)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: request mux in IDLE, response routing to owner in BUSY; IDLE responses are dropped
  always_comb begin
    dmem.req   = 1'b0;
    dmem.cmd   = r0_pl.cmd;
    dmem.width = r0_pl.width;
    dmem.addr  = r0_pl.addr;
    dmem.wdata = r0_pl.wdata;
    r0.req_ack = 1'b0;
    r1.req_ack = 1'b0;
    r0.rdata   = '0;
    r1.rdata   = '0;
    r0.resp    = SCR1_MEM_RESP_NOTRDY;
    r1.resp    = SCR1_MEM_RESP_NOTRDY;
    case (state)
      ST_IDLE: begin
        dmem.req   = req_any;
        dmem.cmd   = sel_pl.cmd;
        dmem.width = sel_pl.width;
        dmem.addr  = sel_pl.addr;
        dmem.wdata = sel_pl.wdata;
        r0.req_ack = dmem.req_ack & ~grant & r0.req;
        r1.req_ack = dmem.req_ack &  grant & r1.req;
      end
      ST_BUSY: begin
        if (owner == SCR1_DMEM_ARB_EXT) begin
          r1.rdata = dmem.rdata;
          r1.resp  = dmem.resp;
        end else begin
          r0.rdata = dmem.rdata;
          r0.resp  = dmem.resp;
        end
      end
      default: ;
    endcase
  end

  assign arb_busy  = (state == ST_BUSY);
  assign arb_owner = owner;

endmodule

// File: tb/tb_scr1_dmem_arb.sv
// Directed bench: round-robin instance (a) and fixed-priority instance (b) share one stimulus.
module tb_scr1_dmem_arb;
  import scr1_dmem_arb_pkg::*;

  logic clk;
  logic rst;

  logic                        r0_req, r1_req;
  type_scr1_mem_cmd_e          r0_cmd, r1_cmd;
  type_scr1_mem_width_e        r0_width, r1_width;
  logic [SCR1_DMEM_AWIDTH-1:0] r0_addr, r1_addr;
  logic [SCR1_DMEM_DWIDTH-1:0] r0_wdata, r1_wdata;
  logic                        dm_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] dm_rdata;
  type_scr1_mem_resp_e         dm_resp;

  logic busy_a, owner_a, busy_b, owner_b;

  int n_chk;
  int n_err;

  scr1_dmem_arb_if r0_a ();
  scr1_dmem_arb_if r1_a ();
  scr1_dmem_arb_if dm_a ();
  scr1_dmem_arb_if r0_b ();
  scr1_dmem_arb_if r1_b ();
  scr1_dmem_arb_if dm_b ();

  assign r0_a.req = r0_req;   assign r0_b.req = r0_req;
  assign r0_a.cmd = r0_cmd;   assign r0_b.cmd = r0_cmd;
  assign r0_a.width = r0_width; assign r0_b.width = r0_width;
  assign r0_a.addr = r0_addr; assign r0_b.addr = r0_addr;
  assign r0_a.wdata = r0_wdata; assign r0_b.wdata = r0_wdata;
  assign r1_a.req = r1_req;   assign r1_b.req = r1_req;
  assign r1_a.cmd = r1_cmd;   assign r1_b.cmd = r1_cmd;
  assign r1_a.width = r1_width; assign r1_b.width = r1_width;
  assign r1_a.addr = r1_addr; assign r1_b.addr = r1_addr;
  assign r1_a.wdata = r1_wdata; assign r1_b.wdata = r1_wdata;
  assign dm_a.req_ack = dm_ack;   assign dm_b.req_ack = dm_ack;
  assign dm_a.rdata = dm_rdata;   assign dm_b.rdata = dm_rdata;
  assign dm_a.resp = dm_resp;     assign dm_b.resp = dm_resp;

  scr1_dmem_arb #(.FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .rst(rst), .r0(r0_a), .r1(r1_a), .dmem(dm_a),
    .arb_busy(busy_a), .arb_owner(owner_a)
  );

  scr1_dmem_arb #(.FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .rst(rst), .r0(r0_b), .r1(r1_b), .dmem(dm_b),
    .arb_busy(busy_b), .arb_owner(owner_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 1'b0; r1_req = 1'b0; dm_ack = 1'b0;
    dm_resp = SCR1_MEM_RESP_NOTRDY; dm_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_own;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    r0_cmd = SCR1_MEM_CMD_RD; r0_width = SCR1_MEM_WIDTH_WORD; r0_addr = '0; r0_wdata = '0;
    r1_cmd = SCR1_MEM_CMD_RD; r1_width = SCR1_MEM_WIDTH_WORD; r1_addr = '0; r1_wdata = '0;
    idle_inputs();
    step();
    // reset state
    chk("rst_dmem_req", 32'(dm_a.req), 32'd0);
    chk("rst_r0_ack", 32'(r0_a.req_ack), 32'd0);
    chk("rst_r0_resp", 32'(r0_a.resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst_r1_rdata", r1_a.rdata, 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_owner", 32'(owner_a), 32'd0);
    rst = 1'b0;
    step();

    // single LSU read
    r0_req = 1'b1; r0_cmd = SCR1_MEM_CMD_RD; r0_width = SCR1_MEM_WIDTH_WORD;
    r0_addr = 32'h0000_0100; dm_ack = 1'b1;
    #1;
    chk("rd_dmem_req", 32'(dm_a.req), 32'd1);
    chk("rd_dmem_addr", dm_a.addr, 32'h0000_0100);
    chk("rd_dmem_cmd", 32'(dm_a.cmd), 32'(SCR1_MEM_CMD_RD));
    chk("rd_r0_ack", 32'(r0_a.req_ack), 32'd1);
    chk("rd_r1_ack", 32'(r1_a.req_ack), 32'd0);
    step();
    r0_req = 1'b0; dm_ack = 1'b0; dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_busy", 32'(busy_a), 32'd1);
    chk("rd_busy_dmem_req", 32'(dm_a.req), 32'd0);
    chk("rd_r0_rdata", r0_a.rdata, 32'hDEAD_BEEF);
    chk("rd_r0_resp", 32'(r0_a.resp), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("rd_r1_resp", 32'(r1_a.resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rd_r1_rdata", r1_a.rdata, 32'd0);
    step();
    idle_inputs();
    #1;
    chk("rd_busy_done", 32'(busy_a), 32'd0);

    // contention: a alternates 0,1,0,1; b always grants r0
    do_reset();
    r0_req = 1'b1; r0_addr = 32'h0000_0010;
    r1_req = 1'b1; r1_addr = 32'h0000_0020;
    for (int t = 0; t < 4; t++) begin
      exp_own = t % 2;
      dm_ack = 1'b1; dm_resp = SCR1_MEM_RESP_NOTRDY;
      #1;
      chk("rr_addr", dm_a.addr, (exp_own == 1) ? 32'h20 : 32'h10);
      chk("rr_r0_ack", 32'(r0_a.req_ack), (exp_own == 0) ? 32'd1 : 32'd0);
      chk("rr_r1_ack", 32'(r1_a.req_ack), (exp_own == 1) ? 32'd1 : 32'd0);
      chk("fp_addr", dm_b.addr, 32'h10);
      chk("fp_r1_ack", 32'(r1_b.req_ack), 32'd0);
      step();
      dm_ack = 1'b0; dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = 32'(t + 5);
      #1;
      chk("rr_owner", 32'(owner_a), 32'(exp_own));
      chk("rr_owner_rdata", (exp_own == 1) ? r1_a.rdata : r0_a.rdata, 32'(t + 5));
      chk("fp_owner", 32'(owner_b), 32'd0);
      chk("fp_r1_resp", 32'(r1_b.resp), 32'(SCR1_MEM_RESP_NOTRDY));
      step();
    end
    idle_inputs();
    #1;

    // grant lock: r1 held un-acked while r0 joins (rr_last now favours r0)
    r1_req = 1'b1; r1_cmd = SCR1_MEM_CMD_WR; r1_addr = 32'h0000_0200; r1_wdata = 32'h5555_AAAA;
    r0_addr = 32'h0000_0300;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) r0_req = 1'b1;
      #1;
      chk("lock_addr", dm_a.addr, 32'h0000_0200);
      chk("lock_r0_ack", 32'(r0_a.req_ack), 32'd0);
      chk("lock_fp_addr", dm_b.addr, 32'h0000_0200);
      step();
    end
    dm_ack = 1'b1;
    #1;
    chk("lock_ack_addr", dm_a.addr, 32'h0000_0200);
    chk("lock_ack_cmd", 32'(dm_a.cmd), 32'(SCR1_MEM_CMD_WR));
    chk("lock_ack_wdata", dm_a.wdata, 32'h5555_AAAA);
    chk("lock_ack_r1", 32'(r1_a.req_ack), 32'd1);
    chk("lock_ack_r0", 32'(r0_a.req_ack), 32'd0);
    step();

    // error response to r1 write
    idle_inputs();
    dm_resp = SCR1_MEM_RESP_RDY_ER;
    #1;
    chk("er_r1_resp", 32'(r1_a.resp), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("er_r0_resp", 32'(r0_a.resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("er_busy", 32'(busy_a), 32'd1);
    step();
    dm_resp = SCR1_MEM_RESP_NOTRDY;
    #1;
    chk("er_idle", 32'(busy_a), 32'd0);

    // reset while BUSY, then a stray response
    r0_req = 1'b1; r0_cmd = SCR1_MEM_CMD_RD; r0_addr = 32'h0000_0300; dm_ack = 1'b1;
    step();
    idle_inputs();
    #1;
    chk("mr_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_async_busy", 32'(busy_a), 32'd0);
    step();
    rst = 1'b0;
    dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = 32'hBAD0_BAD0;
    #1;
    chk("stray_r0_resp", 32'(r0_a.resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("stray_r1_resp", 32'(r1_a.resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("stray_r0_rdata", r0_a.rdata, 32'd0);
    step();
    chk("stray_busy", 32'(busy_a), 32'd0);
    dm_resp = SCR1_MEM_RESP_NOTRDY;
    r0_req = 1'b1; r0_addr = 32'h0000_0400; dm_ack = 1'b1;
    #1;
    chk("post_r0_ack", 32'(r0_a.req_ack), 32'd1);
    chk("post_addr", dm_a.addr, 32'h0000_0400);
    step();
    idle_inputs();
    dm_resp = SCR1_MEM_RESP_RDY_OK; dm_rdata = 32'h1234_5678;
    #1;
    chk("post_r0_rdata", r0_a.rdata, 32'h1234_5678);
    step();
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
